// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: one full-adder cell plus a carry flip-flop, LSB first.
// Latency: a start accepted at edge E gives bits after edges E+1..E+WIDTH; the result registers update at E+WIDTH.
// Backpressure: none. start is sampled only in IDLE and ignored while an operation is in flight.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start, a, b, cin   request and operands, captured together when start is accepted
//   busy, done      busy while bits are processed; done pulses for one cycle when the result updates
//   sum, cout, ovf  final result, unsigned carry-out and signed overflow (held between operations)
//   s_bit, s_valid  per-bit serial result stream, one qualified pulse per bit
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             s_bit,
    output logic             s_valid
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             load;
    logic             step;
    logic             last;
    logic             fa_bit;
    logic             fa_c;

    // Single full-adder cell working on the current LSBs and the carry FF.
    assign fa_bit = a_sh[0] ^ b_sh[0] ^ c;
    assign fa_c   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == LAST_BIT) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            r_sh    <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            s_bit   <= 1'b0;
            s_valid <= 1'b0;
        end else begin
            s_valid <= step;
            if (load) begin
                a_sh <= a;
                b_sh <= b;
                c    <= cin;
                cnt  <= '0;
            end
            if (step) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                r_sh  <= {fa_bit, r_sh[WIDTH-1:1]};
                c     <= fa_c;
                s_bit <= fa_bit;
                if (last) begin
                    // On the MSB step c still holds the carry into the MSB.
                    sum  <= {fa_bit, r_sh[WIDTH-1:1]};
                    cout <= fa_c;
                    ovf  <= c ^ fa_c;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cin   = 1'b0;
    logic [31:0] a_bus = '0;
    logic [31:0] b_bus = '0;

    wire         busy8, done8, cout8, ovf8, sbit8, sv8;
    wire [7:0]   sum8;
    wire         busy16, done16, cout16, ovf16, sbit16, sv16;
    wire [15:0]  sum16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8),
        .s_bit(sbit8), .s_valid(sv8)
    );

    serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a_bus[15:0]), .b(b_bus[15:0]), .cin(cin),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16),
        .s_bit(sbit16), .s_valid(sv16)
    );

    // DUT outputs gathered per instance so the model and checker can loop.
    logic        d_busy [2];
    logic        d_done [2];
    logic        d_cout [2];
    logic        d_ovf  [2];
    logic        d_sbit [2];
    logic        d_sv   [2];
    logic [31:0] d_sum  [2];
    assign d_busy[0] = busy8;   assign d_busy[1] = busy16;
    assign d_done[0] = done8;   assign d_done[1] = done16;
    assign d_cout[0] = cout8;   assign d_cout[1] = cout16;
    assign d_ovf[0]  = ovf8;    assign d_ovf[1]  = ovf16;
    assign d_sbit[0] = sbit8;   assign d_sbit[1] = sbit16;
    assign d_sv[0]   = sv8;     assign d_sv[1]   = sv16;
    assign d_sum[0]  = {24'd0, sum8};
    assign d_sum[1]  = {16'd0, sum16};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // Reference model: an operation is the arithmetic sum a+b+cin, computed at once.
    // pos counts edges since acceptance (-1 = idle); outputs follow from the latency rules.
    int          W   [2] = '{8, 16};
    int          pos [2] = '{-1, -1};
    logic [63:0] res [2] = '{64'd0, 64'd0};
    logic        pend_ovf [2] = '{1'b0, 1'b0};
    logic [31:0] m_sum  [2] = '{32'd0, 32'd0};
    logic        m_cout [2] = '{1'b0, 1'b0};
    logic        m_ovf  [2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pos[i]    = -1;
                m_sum[i]  = '0;
                m_cout[i] = 1'b0;
                m_ovf[i]  = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pos[i] < 0) begin
                    if (start) begin
                        longint unsigned mask, av, bv;
                        logic sa, sb, ss;
                        mask = (64'd1 << W[i]) - 64'd1;
                        av   = {32'd0, a_bus} & mask;
                        bv   = {32'd0, b_bus} & mask;
                        res[i] = av + bv + {63'd0, cin};
                        sa = av[W[i]-1];
                        sb = bv[W[i]-1];
                        ss = res[i][W[i]-1];
                        pend_ovf[i] = (sa == sb) && (ss != sa);
                        pos[i] = 0;
                    end
                end else begin
                    pos[i] = pos[i] + 1;
                    if (pos[i] == W[i]) begin
                        m_sum[i]  = res[i][31:0] & ((32'd1 << W[i]) - 32'd1);
                        m_cout[i] = res[i][W[i]];
                        m_ovf[i]  = pend_ovf[i];
                    end
                    if (pos[i] == W[i] + 1) pos[i] = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk1($sformatf("busy_w%0d", W[i]), d_busy[i], (pos[i] >= 0) && (pos[i] < W[i]));
            chk1($sformatf("done_w%0d", W[i]), d_done[i], pos[i] == W[i]);
            chk1($sformatf("s_valid_w%0d", W[i]), d_sv[i], (pos[i] >= 1) && (pos[i] <= W[i]));
            chk($sformatf("sum_w%0d", W[i]), d_sum[i], m_sum[i]);
            chk1($sformatf("cout_w%0d", W[i]), d_cout[i], m_cout[i]);
            chk1($sformatf("ovf_w%0d", W[i]), d_ovf[i], m_ovf[i]);
            if (pos[i] >= 1 && pos[i] <= W[i])
                chk1($sformatf("s_bit_w%0d", W[i]), d_sbit[i], res[i][pos[i]-1]);
        end
    end

    // Activity counters on the 8-bit instance for the hand-computed checks.
    int         busy_cnt = 0;
    int         sv_cnt   = 0;
    int         done_cnt = 0;
    logic [7:0] stream   = '0;

    always @(negedge clk) begin
        if (busy8) busy_cnt++;
        if (done8) done_cnt++;
        if (sv8) begin
            sv_cnt++;
            stream = {sbit8, stream[7:1]};
        end
    end

    // Start one operation and wait (bounded) for done on the selected instance.
    // If spur > 0, a start with different operands is pulsed spur cycles in.
    task automatic run(input logic [31:0] av, input logic [31:0] bv, input logic c,
                       input int spur, input int sel, output int k);
        logic seen;
        @(posedge clk); #1;
        busy_cnt = 0; sv_cnt = 0; done_cnt = 0; stream = '0;
        a_bus = av; b_bus = bv; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            seen = sel ? done16 : done8;
            if (!seen) begin
                @(posedge clk); #1;
                k++;
                if (k == spur) begin
                    start = 1'b1; a_bus = $urandom; b_bus = $urandom; cin = $urandom_range(0, 1);
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk1("done_seen", seen, 1'b1);
        #1;
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_busy", busy8, 1'b0);
        chk1("rst_done", done8, 1'b0);
        chk1("rst_s_valid", sv8, 1'b0);
        chk("rst_sum", {24'd0, sum8}, 32'h0);
        chk1("rst_cout", cout8, 1'b0);
        chk1("rst_ovf", ovf8, 1'b0);
        rst_n = 1'b1;

        run(32'h0F, 32'h01, 1'b0, 0, 0, k);
        chk("lat_0f01", k, 8);
        chk("sum_0f01", {24'd0, sum8}, 32'h10);
        chk1("cout_0f01", cout8, 1'b0);
        chk1("ovf_0f01", ovf8, 1'b0);
        chk("stream_0f01", {24'd0, stream}, 32'h10);
        chk("busy_cycles", busy_cnt, 8);
        chk("s_valid_pulses", sv_cnt, 8);
        chk("done_pulses", done_cnt, 1);

        run(32'hFF, 32'h01, 1'b0, 0, 0, k);
        chk("sum_ff01", {24'd0, sum8}, 32'h00);
        chk1("cout_ff01", cout8, 1'b1);
        chk1("ovf_ff01", ovf8, 1'b0);
        run(32'h7F, 32'h01, 1'b0, 0, 0, k);
        chk("sum_7f01", {24'd0, sum8}, 32'h80);
        chk1("cout_7f01", cout8, 1'b0);
        chk1("ovf_7f01", ovf8, 1'b1);
        run(32'h80, 32'h80, 1'b0, 0, 0, k);
        chk("sum_8080", {24'd0, sum8}, 32'h00);
        chk1("cout_8080", cout8, 1'b1);
        chk1("ovf_8080", ovf8, 1'b1);

        run(32'h00, 32'h00, 1'b1, 0, 0, k);
        chk("sum_0000c", {24'd0, sum8}, 32'h01);
        chk1("cout_0000c", cout8, 1'b0);
        run(32'hFF, 32'hFF, 1'b1, 0, 0, k);
        chk("sum_ffffc", {24'd0, sum8}, 32'hFF);
        chk1("cout_ffffc", cout8, 1'b1);
        chk1("ovf_ffffc", ovf8, 1'b0);

        run(32'h12, 32'h34, 1'b0, 3, 0, k);
        chk("sum_1234", {24'd0, sum8}, 32'h46);
        chk("ign_done_pulses", done_cnt, 1);
        chk("ign_s_valid_pulses", sv_cnt, 8);

        // Abort after four SHIFT edges.
        @(posedge clk); #1;
        done_cnt = 0;
        a_bus = 32'h3C; b_bus = 32'h0F; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_sum", {24'd0, sum8}, 32'h0);
        chk1("abort_busy", busy8, 1'b0);
        chk1("abort_s_valid", sv8, 1'b0);
        chk1("abort_done", done8, 1'b0);
        chk1("abort_cout", cout8, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("abort_no_done", done_cnt, 0);
        run(32'h05, 32'h03, 1'b0, 0, 0, k);
        chk("sum_0503", {24'd0, sum8}, 32'h08);

        // Let the wide instance drain before the random phase.
        repeat (25) @(posedge clk);
        for (int n = 0; n < 200; n++) begin
            run($urandom, $urandom, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? 3 : 0, 1, k);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
